pl_ex_rns_mc: RTL

Parametrised multi-cycle execute stage for the RNS pipeline. It performs modular add, subtract, multiply and pass operations across `NUM_DOMAINS` residue channels of configurable width. It also runs plain binary arithmetic in domain 0 for integer-file operations. The block sits between IFID and MEMWB and replaces the single-cycle EX stage. It uses valid/ready handshakes and back-pressures IFID while an iterative modular multiply is in flight.

---
 rtl/pl_rns_pkg.sv | 20 ++
 rtl/rns_modmul_seq.sv | 56 +++++
 rtl/pl_ex_rns_mc.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pl_rns_pkg.sv
// Shared types and default moduli for the RNS execute stage.
package pl_rns_pkg;

   typedef enum logic [2:0] {
      EX_ADD    = 3'd0,
      EX_SUB    = 3'd1,
      EX_MUL    = 3'd2,
      EX_PASS_A = 3'd3,
      EX_PASS_B = 3'd4
   } ex_op_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MUL_RUN = 1'b1
   } ex_state_t;

   // Domain 0 in the low field (129), domain 1 above it (256).
   localparam logic [17:0] PL_RNS_MODULI_DEF = {9'd256, 9'd129};

endpackage

// File: rtl/rns_modmul_seq.sv
// Per-domain MSB-first double-and-add modular multiplier; counter and FSM live in the top.
// Only built when PL_EX_SEQ_MUL_EN is defined.
`ifdef PL_EX_SEQ_MUL_EN
module rns_modmul_seq
#(
   parameter int                 DOM_WID = 8,
   parameter logic [DOM_WID+1:0] MOD     = 10'd129
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [DOM_WID-1:0] a,
   input  logic [DOM_WID-1:0] b,
   input  logic               step,
   output logic [DOM_WID-1:0] r
);
   localparam int IW = DOM_WID + 2;

   logic [DOM_WID-1:0] r_q, r_d, a_q, a_d, b_q, b_d;
   logic [IW-1:0]      dbl, dbl_m, acc, acc_m;

   // r is the value after this cycle's step, so the top can capture the last one directly.
   assign dbl   = {1'b0, r_q, 1'b0};
   assign dbl_m = (dbl >= MOD) ? dbl - MOD : dbl;
   assign acc   = dbl_m + {2'b00, a_q};
   assign acc_m = b_q[DOM_WID-1] ? ((acc >= MOD) ? acc - MOD : acc) : dbl_m;
   assign r     = DOM_WID'(acc_m);

   always_comb begin
      r_d = r_q;
      a_d = a_q;
      b_d = b_q;
      if (start) begin
         r_d = '0;
         a_d = a;
         b_d = b;
      end else if (step) begin
         r_d = r;
         b_d = b_q << 1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
         a_q <= '0;
         b_q <= '0;
      end else begin
         r_q <= r_d;
         a_q <= a_d;
         b_q <= b_d;
      end
   end

endmodule
`endif

// File: rtl/pl_ex_rns_mc.sv
// Multi-cycle RNS / binary execute stage. PL_EX_SEQ_MUL_EN selects the iterative RNS multiply.
// state      | meaning
// ST_IDLE    | accepting ops, single-cycle results
// ST_MUL_RUN | iterative RNS multiply, one multiplier bit per cycle
module pl_ex_rns_mc
   import pl_rns_pkg::*;
#(
   parameter int                                   NUM_DOMAINS = 2,
   parameter int                                   DOM_WID     = 8,
   parameter logic [NUM_DOMAINS*(DOM_WID+1)-1:0]   MODULI      = PL_RNS_MODULI_DEF,
   parameter int                                   ADDR_WID    = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [2:0]                     op,
   input  logic                           rns_op,
   input  logic [NUM_DOMAINS*DOM_WID-1:0] op_a,
   input  logic [NUM_DOMAINS*DOM_WID-1:0] op_b,
   input  logic [ADDR_WID-1:0]            dest_addr,
   input  logic                           wr_en,
   input  logic                           flush,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUM_DOMAINS*DOM_WID-1:0] result,
   output logic                           carry,
   output logic [ADDR_WID-1:0]            dest_addr_o,
   output logic                           wr_en_o,
   output logic                           busy
);
   localparam int DW = NUM_DOMAINS * DOM_WID;
   localparam int MW = DOM_WID + 1;
   localparam int IW = DOM_WID + 2;

   ex_op_t              op_e;
   logic                accept, mul_start, mul_step, mul_done, in_idle;
   logic [DW-1:0]       rns_vec, mul_vec, res_calc;
   logic                carry_calc;
   logic [DOM_WID-1:0]  a0, b0, bin_mul;
   logic [MW-1:0]       bin_add, bin_sub;

   logic                out_valid_q, out_valid_d, carry_q, carry_d, wr_en_q, wr_en_d;
   logic [DW-1:0]       result_q, result_d;
   logic [ADDR_WID-1:0] dest_q, dest_d;

   assign op_e = ex_op_t'(op);

   for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
      localparam logic [IW-1:0] M = IW'(MODULI[i*MW +: MW]);
      logic [DOM_WID-1:0] a_i, b_i, mul_i, rns_i;
      logic [IW-1:0]      sum, dif;

      assign a_i = op_a[i*DOM_WID +: DOM_WID];
      assign b_i = op_b[i*DOM_WID +: DOM_WID];
      assign sum = IW'(a_i) + IW'(b_i);
      assign dif = IW'(a_i) - IW'(b_i) + ((a_i < b_i) ? M : '0);

`ifdef PL_EX_SEQ_MUL_EN
      rns_modmul_seq #(.DOM_WID(DOM_WID), .MOD(M)) u_modmul (
         .clk   (clk),
         .reset (reset),
         .start (mul_start),
         .a     (a_i),
         .b     (b_i),
         .step  (mul_step),
         .r     (mul_i)
      );
`else
      assign mul_i = DOM_WID'(((2*DOM_WID)'(a_i) * (2*DOM_WID)'(b_i)) % (2*DOM_WID)'(M));
`endif

      always_comb begin
         case (op_e)
            EX_ADD:    rns_i = (sum >= M) ? DOM_WID'(sum - M) : DOM_WID'(sum);
            EX_SUB:    rns_i = DOM_WID'(dif);
            EX_MUL:    rns_i = mul_i;
            EX_PASS_A: rns_i = a_i;
            EX_PASS_B: rns_i = b_i;
            default:   rns_i = '0;
         endcase
      end

      assign rns_vec[i*DOM_WID +: DOM_WID] = rns_i;
      assign mul_vec[i*DOM_WID +: DOM_WID] = mul_i;
   end

   assign a0      = op_a[DOM_WID-1:0];
   assign b0      = op_b[DOM_WID-1:0];
   assign bin_add = MW'(a0) + MW'(b0);
   assign bin_sub = MW'(a0) - MW'(b0);
   assign bin_mul = DOM_WID'(a0 * b0);

   always_comb begin
      res_calc   = '0;
      carry_calc = 1'b0;
      if (rns_op) begin
         res_calc = rns_vec;
      end else begin
         case (op_e)
            EX_ADD:    {carry_calc, res_calc[DOM_WID-1:0]} = bin_add;
            EX_SUB:    {carry_calc, res_calc[DOM_WID-1:0]} = bin_sub;
            EX_MUL:    res_calc[DOM_WID-1:0] = bin_mul;
            EX_PASS_A: res_calc[DOM_WID-1:0] = a0;
            EX_PASS_B: res_calc[DOM_WID-1:0] = b0;
            default:   res_calc = '0;
         endcase
      end
   end

`ifdef PL_EX_SEQ_MUL_EN
   localparam int CW = $clog2(DOM_WID + 1);
   ex_state_t      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   assign mul_start = accept && rns_op && (op_e == EX_MUL);
   assign mul_step  = (state_q == ST_MUL_RUN) && !flush;
   assign mul_done  = mul_step && (cnt_q == '0);
   assign in_idle   = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_MUL_RUN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (state_q == ST_IDLE) begin
         if (mul_start) begin
            state_d = ST_MUL_RUN;
            cnt_d   = CW'(DOM_WID - 1);
         end
      end else if (cnt_q == '0) begin
         state_d = ST_IDLE;
      end else begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign mul_start = 1'b0;
   assign mul_step  = 1'b0;
   assign mul_done  = 1'b0;
   assign in_idle   = 1'b1;
   assign busy      = 1'b0;
`endif

   // Gated by reset so upstream never sees a ready stage while reset is held.
   assign in_ready = !reset && in_idle && (!out_valid_q || out_ready) && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q && !out_ready;
      result_d    = result_q;
      carry_d     = carry_q;
      dest_d      = dest_q;
      wr_en_d     = wr_en_q;
      if (accept) begin
         dest_d  = dest_addr;
         wr_en_d = wr_en;
         if (!mul_start) begin
            out_valid_d = 1'b1;
            result_d    = res_calc;
            carry_d     = carry_calc;
         end
      end
      if (mul_done) begin
         out_valid_d = 1'b1;
         result_d    = mul_vec;
         carry_d     = 1'b0;
      end
      if (flush) out_valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         dest_q      <= '0;
         wr_en_q     <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         dest_q      <= dest_d;
         wr_en_q     <= wr_en_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign result      = result_q;
   assign carry       = carry_q;
   assign dest_addr_o = dest_q;
   assign wr_en_o     = wr_en_q;

endmodule
